// File: rtl/pe_pkt_ingress.sv
// Packet ingress for the PE data-load path.
// Accepts a host word stream framed by in_sop/in_eop, buffers one packet of
// PKT_LEN payload words plus an XOR checksum word, drops malformed packets,
// then replays the payload as a gap-free burst tagged with err_data. After a
// clean packet it waits GAP idle cycles and pulses rd_sop.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_vld/in_rdy            host handshake; a beat transfers on in_vld & in_rdy
//   in_sop/in_eop/in_data    host framing flags and word
//   wr_sop/wr_eop/wr_vld     replay burst framing and valid
//   wr_data, err_data        replayed word and checksum-failure tag
//   rd_sop                   one-cycle PE read-out start
//   drop_cnt, err_cnt        saturating malformed / checksum-failed counters
module pe_pkt_ingress #(
  parameter int unsigned DW      = 32,
  parameter int unsigned PKT_LEN = 10,
  parameter int unsigned GAP     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [DW-1:0] in_data,
  output logic          wr_sop,
  output logic          wr_eop,
  output logic          wr_vld,
  output logic [DW-1:0] wr_data,
  output logic          err_data,
  output logic          rd_sop,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    err_cnt
);

  localparam int unsigned   IW       = $clog2(PKT_LEN + 1);
  localparam int unsigned   GW       = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(PKT_LEN);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_CHECK,
    S_REPLAY,
    S_KICK
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   chk_q;
  logic            chk_err_q;
  logic [GW-1:0]   gap_q;
  logic            in_rdy_q;
  logic            wr_sop_q;
  logic            wr_eop_q;
  logic            wr_vld_q;
  logic [DW-1:0]   wr_data_q;
  logic            err_data_q;
  logic            rd_sop_q;
  logic [7:0]      drop_cnt_q;
  logic [7:0]      err_cnt_q;
  logic [DW-1:0]   buf_q [PKT_LEN];

  logic            xfer_c;
  logic            buf_we_c;
  logic [IW-1:0]   buf_addr_c;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A sop beat always lands at index 0; in-packet beats land at the running index.
  always_comb begin
    xfer_c     = in_vld & in_rdy_q;
    buf_addr_c = in_sop ? '0 : idx_q;
    buf_we_c   = xfer_c & (in_sop | ((state_q == S_RECV) & (idx_q != FULL_IDX)));
  end

  // Packet buffer carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (buf_we_c) buf_q[buf_addr_c] <= in_data;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      chk_q      <= '0;
      chk_err_q  <= 1'b0;
      gap_q      <= '0;
      in_rdy_q   <= 1'b1;
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_data_q  <= '0;
      err_data_q <= 1'b0;
      rd_sop_q   <= 1'b0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      err_data_q <= 1'b0;
      rd_sop_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_rdy_q <= 1'b1;
          if (xfer_c && in_sop) begin
            if (in_eop) begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end else begin
              acc_q   <= in_data;
              idx_q   <= IW'(1);
              state_q <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (xfer_c) begin
            if (in_sop) begin
              // Old packet is abandoned; the new one restarts at index 0.
              drop_cnt_q <= sat_inc(drop_cnt_q);
              if (in_eop) begin
                state_q <= S_IDLE;
              end else begin
                acc_q <= in_data;
                idx_q <= IW'(1);
              end
            end else if (idx_q != FULL_IDX) begin
              if (in_eop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
                state_q    <= S_IDLE;
              end else begin
                acc_q <= acc_q ^ in_data;
                idx_q <= idx_q + IW'(1);
              end
            end else if (in_eop) begin
              chk_q    <= in_data;
              in_rdy_q <= 1'b0;
              state_q  <= S_CHECK;
            end else begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
              state_q    <= S_DROP;
            end
          end
        end
        S_DROP: begin
          // Already counted; a new sop restarts reception without a second count.
          if (xfer_c) begin
            if (in_sop && !in_eop) begin
              acc_q   <= in_data;
              idx_q   <= IW'(1);
              state_q <= S_RECV;
            end else if (in_eop) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_CHECK: begin
          chk_err_q <= (acc_q != chk_q);
          if (acc_q != chk_q) err_cnt_q <= sat_inc(err_cnt_q);
          idx_q   <= '0;
          state_q <= S_REPLAY;
        end
        S_REPLAY: begin
          // One extra step after the last beat so in_rdy rises the cycle after wr_eop.
          if (idx_q != FULL_IDX) begin
            wr_vld_q   <= 1'b1;
            wr_sop_q   <= (idx_q == '0);
            wr_eop_q   <= (idx_q == LAST_IDX);
            wr_data_q  <= buf_q[idx_q];
            err_data_q <= chk_err_q;
            idx_q      <= idx_q + IW'(1);
          end else if (chk_err_q) begin
            in_rdy_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            gap_q   <= '0;
            state_q <= S_KICK;
          end
        end
        S_KICK: begin
          if (gap_q == GAP_LAST) begin
            rd_sop_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_rdy   = in_rdy_q;
  assign wr_sop   = wr_sop_q;
  assign wr_eop   = wr_eop_q;
  assign wr_vld   = wr_vld_q;
  assign wr_data  = wr_data_q;
  assign err_data = err_data_q;
  assign rd_sop   = rd_sop_q;
  assign drop_cnt = drop_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
